uart_tx_param: RTL and testbench

Parametrised UART transmitter: the next generation of the team's fixed 8-bit serial TX block. It adds configurable data width, oversampling ratio, parity mode and stop-bit count, plus a valid/ready handshake, and sends data LSB-first. It sits between a byte/word producer (CPU register, FIFO) and the board TX pin. It is paced by an external baud-rate generator that supplies a single-cycle `baud_tick` strobe at OVERSAMPLE × baud.

---
 rtl/uart_tx_param_if.sv | 12 +
 rtl/uart_tx_param.sv | 126 ++++++++++++
 tb/tb_uart_tx_param.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_param_if.sv
// Producer-side handshake for the parametrised UART transmitter.
// The master drives words; the slave (transmitter) signals when it can take one.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: LSB-first frames with optional parity and 1/2 stop bits,
// paced by an external oversampled baud strobe, with a valid/ready word handshake.
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               baud_tick,
    uart_tx_param_if.slave     bus,
    output logic               tx,
    output logic               busy
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;

    // A bit period closes on the tick that completes OVERSAMPLE ticks; never in IDLE.
    assign bit_end = baud_tick && (state_q != S_IDLE) &&
                     (tick_q == TICK_W'(OVERSAMPLE - 1));

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;

        if (state_q != S_IDLE && baud_tick) begin
            tick_d = bit_end ? '0 : tick_q + TICK_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.tx_valid) begin
                    state_d = S_START;
                    shift_d = bus.tx_data;
                    par_d   = (PARITY == 1) ? ~(^bus.tx_data) : (^bus.tx_data);
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line level is decoded from next state so tx itself is a clean flop output.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign bus.tx_ready = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign tx           = tx_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameter sets share clock, reset and baud strobe;
// frames are sampled mid-bit and compared with hand-computed bit patterns.
module tb_uart_tx_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       vld [4];
    logic [8:0] dat = '0;
    int         sel = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    logic tx0, tx1, tx2, tx3, bz0, bz1, bz2, bz3;
    logic tx_sel, rdy_sel, busy_sel;

    uart_tx_param_if #(.DATA_BITS(8)) if0 ();
    uart_tx_param_if #(.DATA_BITS(8)) if1 ();
    uart_tx_param_if #(.DATA_BITS(8)) if2 ();
    uart_tx_param_if #(.DATA_BITS(7)) if3 ();

    assign if0.tx_valid = vld[0];
    assign if1.tx_valid = vld[1];
    assign if2.tx_valid = vld[2];
    assign if3.tx_valid = vld[3];
    assign if0.tx_data  = dat[7:0];
    assign if1.tx_data  = dat[7:0];
    assign if2.tx_data  = dat[7:0];
    assign if3.tx_data  = dat[6:0];

    uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if0), .tx(tx0), .busy(bz0));
    uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if1), .tx(tx1), .busy(bz1));
    uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if2), .tx(tx2), .busy(bz2));
    uart_tx_param #(.DATA_BITS(7), .OVERSAMPLE(4), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if3), .tx(tx3), .busy(bz3));

    always_comb begin
        tx_sel = tx0; rdy_sel = if0.tx_ready; busy_sel = bz0;
        case (sel)
            1: begin tx_sel = tx1; rdy_sel = if1.tx_ready; busy_sel = bz1; end
            2: begin tx_sel = tx2; rdy_sel = if2.tx_ready; busy_sel = bz2; end
            3: begin tx_sel = tx3; rdy_sel = if3.tx_ready; busy_sel = bz3; end
            default: ;
        endcase
    end

    always #5 clk = ~clk;

    // Baud strobe: one clk high in every three, updated just after the rising edge.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph == 2) ? 0 : ph + 1;
            baud_tick = (ph == 2);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input int idx, input logic [8:0] d, input bit aligned, input bit keep);
        sel = idx;
        dat = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (baud_tick == aligned) break;
        end
        vld[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!keep) vld[idx] = 1'b0;
        check("start_bit", tx_sel, 0);
        check("ready_low", rdy_sel, 0);
        check("busy_high", busy_sel, 1);
    endtask

    task automatic capture(input int os, input int nb, input bit disturb,
                           output logic [15:0] bits, output int ticks, output bit on_tick);
        int cnt;
        bit tk;
        cnt = 0; bits = '0; on_tick = 1'b0; ticks = -1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            tk = baud_tick;
            if (tk) cnt++;
            @(negedge clk);
            for (int k = 0; k < nb; k++)
                if (tk && cnt == k * os + os / 2) bits[k] = tx_sel;
            if (disturb && tk && cnt == 40) begin vld[sel] = 1'b1; dat = 9'h1FF; end
            if (disturb && tk && cnt == 48) vld[sel] = 1'b0;
            if (rdy_sel) begin
                ticks = cnt;
                on_tick = tk;
                return;
            end
        end
        check("frame_timeout", 0, 1);
    endtask

    task automatic run_frame(input string tag, input int os, input int nb, input bit disturb,
                             input logic [15:0] exp_bits, input int exp_ticks);
        logic [15:0] bits;
        int ticks;
        bit on_tick;
        capture(os, nb, disturb, bits, ticks, on_tick);
        check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        check({tag, "_ticks"}, ticks, exp_ticks);
        check({tag, "_ready_after_last_tick"}, 32'(on_tick), 1);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 4; i++) vld[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", tx0, 1);
        check("rst_ready", if0.tx_ready, 1);
        check("rst_busy", bz0, 0);
        check("rst_tx_7n2", tx3, 1);

        // 8N1 0xA5, accept coinciding with a baud tick.
        start_frame(0, 9'h0A5, 1'b1, 1'b0);
        run_frame("8n1_a5", 16, 10, 1'b0, 16'h034A, 160);

        start_frame(1, 9'h007, 1'b0, 1'b0);
        run_frame("8e1_07", 16, 11, 1'b0, 16'h060E, 176);

        start_frame(2, 9'h007, 1'b0, 1'b0);
        run_frame("8o1_07", 16, 11, 1'b0, 16'h040E, 176);

        start_frame(3, 9'h041, 1'b0, 1'b0);
        run_frame("7n2_41", 4, 10, 1'b0, 16'h0382, 40);

        // Back-to-back with tx_valid held: one idle clk, then the next start bit.
        start_frame(0, 9'h055, 1'b0, 1'b1);
        dat = 9'h0AA;
        run_frame("b2b_55", 16, 10, 1'b0, 16'h02AA, 160);
        check("b2b_gap_idle", tx0, 1);
        @(negedge clk);
        check("b2b_second_start", tx0, 0);
        check("b2b_second_ready", if0.tx_ready, 0);
        vld[0] = 1'b0;
        run_frame("b2b_aa", 16, 10, 1'b0, 16'h0354, 160);

        // tx_data/tx_valid disturbed mid-frame must not alter or restart the frame.
        start_frame(0, 9'h0A5, 1'b0, 1'b0);
        run_frame("midframe", 16, 10, 1'b1, 16'h034A, 160);
        @(negedge clk);
        check("midframe_no_reaccept", bz0, 0);

        // Reset in the middle of data bit 3, then a clean frame.
        start_frame(0, 9'h03C, 1'b0, 1'b0);
        cnt = 0;
        for (int cyc = 0; cyc < 1000 && cnt < 72; cyc++) begin
            @(posedge clk);
            if (baud_tick) cnt++;
        end
        check("rst_wait_ticks", cnt, 72);
        @(negedge clk);
        check("bit3_level", tx0, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", tx0, 1);
        check("async_rst_busy", bz0, 0);
        check("async_rst_ready", if0.tx_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", tx0, 1);
        start_frame(0, 9'h0A5, 1'b0, 1'b0);
        run_frame("post_rst_a5", 16, 10, 1'b0, 16'h034A, 160);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
